// File: rtl/spi_controller_pkg.sv
// Shared definitions for the SPI controller: register offsets, CTRL field positions
// and the serial engine state encoding.
package spi_controller_pkg;

  localparam logic [7:0] ADDR_BASE   = 8'h00;
  localparam logic [7:0] DATA_BASE   = 8'h10;
  localparam logic [7:0] CTRL_OFFSET = 8'h20;

  localparam int CTRL_START   = 0;
  localparam int CTRL_NUM_LSB = 1;
  localparam int CTRL_NUM_MSB = 3;
  localparam int CTRL_SLV_LSB = 4;
  localparam int CTRL_SLV_MSB = 6;
  localparam int CTRL_BUSY    = 7;

  typedef logic [1:0] spi_state_t;
  localparam spi_state_t ST_IDLE = 2'd0;
  localparam spi_state_t ST_ADDR = 2'd1;
  localparam spi_state_t ST_DATA = 2'd2;
  localparam spi_state_t ST_GAP  = 2'd3;

  // 8 bits at 2 pclk cycles per bit; the counter wraps to 0 after this value
  localparam logic [3:0] HALF_CYCLES_LAST = 4'd15;

endpackage

// File: rtl/spi_controller_shift_engine.sv
// Mode-0 serial engine: walks address/data pairs, shifting ADDR then DATA MSB first,
// and returns the bytes captured during read transfers.
module spi_shift_engine
  import spi_controller_pkg::*;
#(
  parameter int NO_SLAVE = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2:0]          start_num,
  input  logic [2:0]          start_slave,
  input  logic [7:0]          addr_byte,
  input  logic [7:0]          data_byte,
  input  logic                miso,
  output logic [2:0]          pair_sel,
  output logic                busy,
  output logic                done,
  output logic                rd_load,
  output logic [7:0]          rd_data,
  output logic                sclk,
  output logic                mosi,
  output logic [NO_SLAVE-1:0] ss
);

  spi_state_t state;
  logic [3:0] half_cnt;
  logic [2:0] idx;
  logic [2:0] num;
  logic [2:0] slave;
  logic [7:0] shreg;
  logic [7:0] rx;
  logic       is_write;
  logic       last_half;

  function automatic logic [NO_SLAVE-1:0] select_mask(input logic [2:0] sel);
    logic [NO_SLAVE-1:0] m;
    m = '1;
    for (int i = 0; i < NO_SLAVE; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  // The GAP cycle already presents the next pair so its address byte is ready on entry
  assign pair_sel  = (state == ST_GAP) ? idx + 3'd1 : idx;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_GAP) && (idx == num);
  assign last_half = (half_cnt == HALF_CYCLES_LAST);
  assign rd_load   = (state == ST_DATA) && last_half && !is_write;
  assign rd_data   = rx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      half_cnt <= 4'd0;
      idx      <= 3'd0;
      num      <= 3'd0;
      slave    <= 3'd0;
      shreg    <= 8'h00;
      rx       <= 8'h00;
      is_write <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_ADDR;
            half_cnt <= 4'd0;
            idx      <= 3'd0;
            num      <= start_num;
            slave    <= start_slave;
            mosi     <= addr_byte[7];
            shreg    <= {addr_byte[6:0], 1'b0};
            is_write <= addr_byte[7];
            ss       <= select_mask(start_slave);
          end
        end
        ST_ADDR, ST_DATA: begin
          sclk     <= ~sclk;
          half_cnt <= half_cnt + 4'd1;
          if (!sclk) begin
            if (state == ST_DATA && !is_write) rx <= {rx[6:0], miso};
          end else if (last_half) begin
            if (state == ST_ADDR) begin
              state <= ST_DATA;
              mosi  <= is_write ? data_byte[7] : 1'b0;
              shreg <= is_write ? {data_byte[6:0], 1'b0} : 8'h00;
            end else begin
              state <= ST_GAP;
              mosi  <= 1'b0;
              ss    <= '1;
            end
          end else begin
            mosi  <= shreg[7];
            shreg <= {shreg[6:0], 1'b0};
          end
        end
        default: begin
          half_cnt <= 4'd0;
          if (idx == num) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
          end else begin
            state    <= ST_ADDR;
            idx      <= idx + 3'd1;
            mosi     <= addr_byte[7];
            shreg    <= {addr_byte[6:0], 1'b0};
            is_write <= addr_byte[7];
            ss       <= select_mask(slave);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/spi_controller.sv
// Register front end and register file for a small SPI master (spi_shift_engine does the wire work).
// Define SPI_SLVERR_EN to flag unmapped accesses and writes while busy on pslverr_o.
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int MAX_TRANSFER = 8,
  parameter int NO_SLAVE     = 4
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [7:0]          paddr_i,
  input  logic [7:0]          pwdata_i,
  output logic [7:0]          prdata_o,
  input  logic                pwrite_i,
  input  logic                penable_i,
  output logic                pready_o,
  output logic                pslverr_o,
  input  logic                sclk_i,
  output logic                sclk_o,
  input  logic                miso,
  output logic                mosi,
  output logic [NO_SLAVE-1:0] ss
);

  logic [7:0] addr_regs [MAX_TRANSFER];
  logic [7:0] data_regs [MAX_TRANSFER];
  logic [CTRL_BUSY-1:0] ctrl_reg;
  logic       busy;
  logic       done;
  logic       rd_load;
  logic [2:0] pair_sel;
  logic [7:0] rd_data;
  logic [7:0] addr_byte;
  logic [7:0] data_byte;
  logic [7:0] read_mux;
  logic       mapped;
  logic       setup;
  logic       commit;
  logic       wr_blocked;
  logic       start;
  logic       unused_sclk;

  assign unused_sclk = sclk_i;

  assign setup  = penable_i && !pready_o;
  assign commit = penable_i && pready_o && pwrite_i && !wr_blocked;
  assign start  = commit && (paddr_i == CTRL_OFFSET) && pwdata_i[CTRL_START];

  always_comb begin
    mapped    = 1'b0;
    read_mux  = 8'h00;
    addr_byte = 8'h00;
    data_byte = 8'h00;
    for (int i = 0; i < MAX_TRANSFER; i++) begin
      if (paddr_i == ADDR_BASE + 8'(i)) begin
        mapped   = 1'b1;
        read_mux = addr_regs[i];
      end
      if (paddr_i == DATA_BASE + 8'(i)) begin
        mapped   = 1'b1;
        read_mux = data_regs[i];
      end
      if (int'(pair_sel) == i) begin
        addr_byte = addr_regs[i];
        data_byte = data_regs[i];
      end
    end
    if (paddr_i == CTRL_OFFSET) begin
      mapped   = 1'b1;
      read_mux = {busy, ctrl_reg};
    end
  end

  // Busy is judged at the setup edge so the dropped write and its error flag always agree
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      pready_o   <= 1'b0;
      prdata_o   <= 8'h00;
      wr_blocked <= 1'b0;
    end else begin
      pready_o   <= setup;
      wr_blocked <= setup && busy;
      prdata_o   <= (setup && !pwrite_i && mapped) ? read_mux : 8'h00;
    end
  end

`ifdef SPI_SLVERR_EN
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      pslverr_o <= 1'b0;
    end else begin
      pslverr_o <= setup && (!mapped || (pwrite_i && busy));
    end
  end
`else
  assign pslverr_o = 1'b0;
`endif

  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      for (int i = 0; i < MAX_TRANSFER; i++) begin
        addr_regs[i] <= 8'h00;
        data_regs[i] <= 8'h00;
      end
      ctrl_reg <= '0;
    end else begin
      if (commit) begin
        for (int i = 0; i < MAX_TRANSFER; i++) begin
          if (paddr_i == ADDR_BASE + 8'(i)) addr_regs[i] <= pwdata_i;
          if (paddr_i == DATA_BASE + 8'(i)) data_regs[i] <= pwdata_i;
        end
        if (paddr_i == CTRL_OFFSET) ctrl_reg <= pwdata_i[CTRL_BUSY-1:0];
      end
      if (rd_load) begin
        for (int i = 0; i < MAX_TRANSFER; i++) begin
          if (int'(pair_sel) == i) data_regs[i] <= rd_data;
        end
      end
      if (done) ctrl_reg[CTRL_START] <= 1'b0;
    end
  end

  spi_shift_engine #(
    .NO_SLAVE(NO_SLAVE)
  ) u_engine (
    .clk        (pclk_i),
    .rst_n      (prst_i),
    .start      (start),
    .start_num  (pwdata_i[CTRL_NUM_MSB:CTRL_NUM_LSB]),
    .start_slave(pwdata_i[CTRL_SLV_MSB:CTRL_SLV_LSB]),
    .addr_byte  (addr_byte),
    .data_byte  (data_byte),
    .miso       (miso),
    .pair_sel   (pair_sel),
    .busy       (busy),
    .done       (done),
    .rd_load    (rd_load),
    .rd_data    (rd_data),
    .sclk       (sclk_o),
    .mosi       (mosi),
    .ss         (ss)
  );

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: directed register and sequence steps plus
// randomized sequences checked against a frame-level model of the serial traffic.
module tb_spi_controller;

`ifdef SPI_SLVERR_EN
  localparam logic EXP_SLVERR = 1'b1;
`else
  localparam logic EXP_SLVERR = 1'b0;
`endif

  logic       pclk_i = 1'b0;
  logic       prst_i;
  logic [7:0] paddr_i;
  logic [7:0] pwdata_i;
  logic [7:0] prdata_o;
  logic       pwrite_i;
  logic       penable_i;
  logic       pready_o;
  logic       pslverr_o;
  logic       sclk_i;
  logic       sclk_o;
  logic       miso;
  logic       mosi;
  logic [3:0] ss;

  int checks = 0;
  int failures = 0;
  int pulse_bad = 0;
  int cyc = 0;
  int commit_cyc = 0;

  logic [7:0] exp_addr [8];
  logic [7:0] exp_data [8];

  logic [3:0]  bit_cnt = 4'd0;
  logic [15:0] cur_frame = 16'h0;
  logic [15:0] miso_word = 16'h0;
  logic        miso_ones = 1'b0;
  logic        sclk_prev = 1'b0;
  logic [3:0]  frame_ss = 4'hF;
  logic        frame_ok = 1'b1;
  logic [15:0] mosi_q [$];
  logic [3:0]  ss_q [$];
  logic [7:0]  miso_q [$];

  spi_controller #(
    .MAX_TRANSFER(8),
    .NO_SLAVE(4)
  ) dut (
    .pclk_i   (pclk_i),
    .prst_i   (prst_i),
    .paddr_i  (paddr_i),
    .pwdata_i (pwdata_i),
    .prdata_o (prdata_o),
    .pwrite_i (pwrite_i),
    .penable_i(penable_i),
    .pready_o (pready_o),
    .pslverr_o(pslverr_o),
    .sclk_i   (sclk_i),
    .sclk_o   (sclk_o),
    .miso     (miso),
    .mosi     (mosi),
    .ss       (ss)
  );

  always #5 pclk_i = ~pclk_i;

  always @(posedge pclk_i) cyc++;

  // The slave model presents frame bit (15 - bit_cnt); it advances after each rising sclk
  assign miso = miso_word[~bit_cnt];

  always @(negedge pclk_i) begin
    if (!prst_i) begin
      bit_cnt   = 4'd0;
      cur_frame = 16'h0;
    end else if (sclk_o && !sclk_prev) begin
      cur_frame = {cur_frame[14:0], mosi};
      if (bit_cnt == 4'd0) begin
        frame_ss = ss;
        frame_ok = 1'b1;
      end else if (ss !== frame_ss) begin
        frame_ok = 1'b0;
      end
      bit_cnt = bit_cnt + 4'd1;
      if (bit_cnt == 4'd0) begin
        mosi_q.push_back(cur_frame);
        ss_q.push_back(frame_ok ? frame_ss : 4'h0);
        miso_q.push_back(miso_word[7:0]);
        miso_word = miso_ones ? 16'hFFFF : 16'($urandom);
      end
    end
    sclk_prev = sclk_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One bus access, started at a falling edge; returns at the falling edge after the commit edge
  task automatic applyStimulus(input logic [7:0] addr, input logic wr, input logic [7:0] wdata,
                               output logic [7:0] rdata, output logic err);
    int waited;
    paddr_i   = addr;
    pwdata_i  = wdata;
    pwrite_i  = wr;
    penable_i = 1'b1;
    waited    = 0;
    do begin
      @(negedge pclk_i);
      waited++;
    end while (pready_o !== 1'b1 && waited < 8);
    if (waited != 1) pulse_bad++;
    rdata = prdata_o;
    err   = pslverr_o;
    @(negedge pclk_i);
    penable_i = 1'b0;
    if (pready_o !== 1'b0) pulse_bad++;
    commit_cyc = cyc;
  endtask

  task automatic regWrite(input logic [7:0] addr, input logic [7:0] data);
    logic [7:0] rd;
    logic       err;
    applyStimulus(addr, 1'b1, data, rd, err);
  endtask

  task automatic regRead(input logic [7:0] addr, output logic [7:0] data);
    logic err;
    applyStimulus(addr, 1'b0, 8'h00, data, err);
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge pclk_i);
  endtask

  // CTRL sampled at edge e0+s must show BUSY with START kept; two cycles later both are clear
  task automatic checkBusyWindow(input string tag, input int e0, input int s, input logic [7:0] ctrl_val);
    logic [7:0] v;
    waitCycle(e0 + s - 1);
    regRead(8'h20, v);
    checkOutput({tag, "_busy"}, v, {1'b1, ctrl_val[6:0]});
    regRead(8'h20, v);
    checkOutput({tag, "_idle"}, v, {1'b0, ctrl_val[6:1], 1'b0});
  endtask

  task automatic checkFrames(input string tag, input logic [2:0] num, input logic [2:0] slave);
    logic [3:0]  exp_ss;
    logic [31:0] obs;
    exp_ss = 4'hF;
    if (slave < 3'd4) exp_ss = 4'hF & ~(4'h1 << slave);
    checkOutput({tag, "_frames"}, mosi_q.size(), int'(num) + 1);
    for (int j = 0; j <= int'(num); j++) begin
      obs = (j < mosi_q.size()) ? {16'h0, mosi_q[j]} : 32'hFFFF_FFFF;
      checkOutput({tag, "_mosi"}, obs, {16'h0, exp_addr[j], exp_addr[j][7] ? exp_data[j] : 8'h00});
      obs = (j < ss_q.size()) ? {28'h0, ss_q[j]} : 32'hFFFF_FFFF;
      checkOutput({tag, "_ss"}, obs, {28'h0, exp_ss});
      if (!exp_addr[j][7] && j < miso_q.size()) exp_data[j] = miso_q[j];
    end
    checkOutput({tag, "_ss_after"}, ss, 4'hF);
  endtask

  task automatic clearMonitor();
    mosi_q.delete();
    ss_q.delete();
    miso_q.delete();
  endtask

  initial begin
    logic [7:0] v;
    logic       err;
    logic [2:0] num;
    logic [2:0] slave;
    logic [7:0] ctrl;
    int         e0;

    prst_i    = 1'b1;
    paddr_i   = 8'h00;
    pwdata_i  = 8'h00;
    pwrite_i  = 1'b0;
    penable_i = 1'b0;
    sclk_i    = 1'b0;
    miso_word = 16'($urandom);
    #1 prst_i = 1'b0;

    // Reset state
    repeat (2) @(negedge pclk_i);
    checkOutput("reset_ss", ss, 4'hF);
    checkOutput("reset_sclk", sclk_o, 1'b0);
    checkOutput("reset_mosi", mosi, 1'b0);
    checkOutput("reset_pready", pready_o, 1'b0);
    checkOutput("reset_prdata", prdata_o, 8'h00);
    prst_i = 1'b1;
    @(negedge pclk_i);

    // Register file write and read back
    for (int i = 0; i < 8; i++) begin
      exp_addr[i] = 8'hD3 + 8'(i);
      exp_data[i] = 8'h46 + 8'(i);
      regWrite(8'(i), exp_addr[i]);
      regWrite(8'h10 + 8'(i), exp_data[i]);
    end
    for (int i = 0; i < 8; i++) begin
      regRead(8'(i), v);
      checkOutput("readback_addr", v, exp_addr[i]);
      regRead(8'h10 + 8'(i), v);
      checkOutput("readback_data", v, exp_data[i]);
    end

    // Unmapped reads
    applyStimulus(8'h08, 1'b0, 8'h00, v, err);
    checkOutput("unmapped_08_data", v, 8'h00);
    checkOutput("unmapped_08_err", err, EXP_SLVERR);
    applyStimulus(8'($urandom_range(8'h21, 8'hFF)), 1'b0, 8'h00, v, err);
    checkOutput("unmapped_hi_data", v, 8'h00);
    checkOutput("unmapped_hi_err", err, EXP_SLVERR);

    // Three write transfers on slave 0, with a CTRL write attempted mid-sequence
    clearMonitor();
    regWrite(8'h20, 8'h05);
    e0 = commit_cyc;
    waitCycle(e0 + 29);
    applyStimulus(8'h20, 1'b1, 8'h07, v, err);
    checkOutput("busy_write_err", err, EXP_SLVERR);
    checkBusyWindow("seq3", e0, 98, 8'h05);
    checkFrames("seq3", 3'd2, 3'd0);

    // Single read transfer with miso held high
    miso_ones = 1'b1;
    miso_word = 16'hFFFF;
    regWrite(8'h00, 8'h12);
    exp_addr[0] = 8'h12;
    clearMonitor();
    regWrite(8'h20, 8'h01);
    e0 = commit_cyc;
    checkBusyWindow("rd1", e0, 33, 8'h01);
    checkFrames("rd1", 3'd0, 3'd0);
    regRead(8'h10, v);
    checkOutput("rd1_data0", v, 8'hFF);
    miso_ones = 1'b0;
    miso_word = 16'($urandom);

    // Randomized sequences, including slave indices with no select line
    for (int it = 0; it < 4; it++) begin
      num   = 3'($urandom_range(0, 3));
      slave = 3'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) begin
        exp_addr[i] = 8'($urandom);
        exp_data[i] = 8'($urandom);
        regWrite(8'(i), exp_addr[i]);
        regWrite(8'h10 + 8'(i), exp_data[i]);
      end
      clearMonitor();
      ctrl = {1'b0, slave, num, 1'b1};
      regWrite(8'h20, ctrl);
      e0 = commit_cyc;
      checkBusyWindow("rand", e0, 33 * (int'(num) + 1), ctrl);
      checkFrames("rand", num, slave);
      for (int i = 0; i < 8; i++) begin
        regRead(8'h10 + 8'(i), v);
        checkOutput("rand_data", v, exp_data[i]);
      end
    end

    // Reset in the middle of a frame
    regWrite(8'h20, 8'h37);
    repeat (10) @(negedge pclk_i);
    prst_i = 1'b0;
    #1;
    checkOutput("midreset_ss", ss, 4'hF);
    checkOutput("midreset_sclk", sclk_o, 1'b0);
    checkOutput("midreset_mosi", mosi, 1'b0);
    repeat (2) @(negedge pclk_i);
    prst_i = 1'b1;
    clearMonitor();
    @(negedge pclk_i);
    regRead(8'h20, v);
    checkOutput("midreset_ctrl", v, 8'h00);
    regRead(8'h00, v);
    checkOutput("midreset_addr0", v, 8'h00);
    repeat (60) @(negedge pclk_i);
    checkOutput("midreset_no_frames", mosi_q.size(), 0);
    checkOutput("midreset_ss_idle", ss, 4'hF);

    checkOutput("pready_pulse", pulse_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
